// File: rtl/go_pkg.sv
// go_pkg: shared cell, board, result and FSM state definitions for move_controller
package go_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, BLACK = 2'b01, WHITE = 2'b10} cell_t;
  typedef cell_t [8:0][8:0] board_t;
  typedef enum logic [1:0] {RES_OK, RES_ILLEGAL, RES_KO, RES_PASS} result_t;
  typedef logic [2:0] state_t;
  localparam logic [7:0] PASS_MOVE = 8'hFF;
  localparam board_t EMPTY_BOARD = board_t'(162'd0);
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_CHECK    = 3'd1;
  localparam state_t S_LAUNCH   = 3'd2;
  localparam state_t S_WAIT_UPD = 3'd3;
  localparam state_t S_KO_CHECK = 3'd4;
  localparam state_t S_COMMIT   = 3'd5;
  localparam state_t S_REPORT   = 3'd6;
endpackage

// File: rtl/stone_counter.sv
// stone_counter: number of cells on a board that hold the given colour
module stone_counter
  import go_pkg::*;
(
  input  board_t     board,
  input  cell_t      colour,
  output logic [6:0] count
);
  // sum of matching cells over the whole board
  always_comb begin
    count = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        count = count + 7'(board[r][c] == colour);
  end
endmodule

// File: rtl/move_controller.sv
// move_controller: validates Go moves, drives the board-update stage and commits its result.
// Optional macro KO_DETECT_EN keeps the previous position and rejects simple-ko recaptures.
module move_controller
  import go_pkg::*;
#(
  parameter int BOARD_N = 9,
  parameter int CAP_W   = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             move_valid_in,
  input  logic [7:0]       move_in,
  output logic             move_ready_out,
  output logic             upd_start_out,
  output board_t           upd_board_out,
  output logic             upd_turn_out,
  output logic [7:0]       upd_move_out,
  input  board_t           upd_board_in,
  input  logic             upd_ready_in,
  output board_t           board_out,
  output logic             turn_out,
  output logic             result_valid_out,
  output logic [1:0]       result_code_out,
  output logic [CAP_W-1:0] black_caps_out,
  output logic [CAP_W-1:0] white_caps_out,
  output logic             game_over_out
);
  state_t state;
  board_t board, new_board;
  result_t result;
  cell_t target, opponent;
  logic turn, pass_flag, game_over, ko, in_range, is_pass, suicide;
  logic [7:0] move;
  logic [3:0] row, col;
  logic [6:0] opp_before, opp_after, gained;
  logic [CAP_W-1:0] black_caps, white_caps, mover_caps, caps_next;
  logic [CAP_W:0] caps_sum;

  assign row = move[7:4];
  assign col = move[3:0];
  assign is_pass = move == PASS_MOVE;
  assign in_range = int'(row) < BOARD_N && int'(col) < BOARD_N;
  assign target = in_range ? board[row][col] : EMPTY;
  assign suicide = new_board[row][col] == EMPTY;
  assign opponent = cell_t'({~turn, turn});

  stone_counter u_before (.board(board), .colour(opponent), .count(opp_before));
  stone_counter u_after (.board(new_board), .colour(opponent), .count(opp_after));

  assign gained = opp_before > opp_after ? opp_before - opp_after : '0;
  assign mover_caps = turn ? white_caps : black_caps;
  assign caps_sum = {1'b0, mover_caps} + (CAP_W+1)'(gained);
  assign caps_next = caps_sum[CAP_W] ? '1 : caps_sum[CAP_W-1:0];

`ifdef KO_DETECT_EN
  board_t prev_board;
  // position before the opponent's last committed move
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) prev_board <= EMPTY_BOARD;
    else if (state == S_COMMIT && result == RES_OK) prev_board <= board;
  assign ko = new_board == prev_board;
`else
  assign ko = 1'b0;
`endif

  // sequencing FSM together with the committed game state; rejected updates still pass COMMIT for fixed latency
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state      <= S_IDLE;
      board      <= EMPTY_BOARD;
      new_board  <= EMPTY_BOARD;
      move       <= '0;
      turn       <= 1'b0;
      pass_flag  <= 1'b0;
      game_over  <= 1'b0;
      result     <= RES_OK;
      black_caps <= '0;
      white_caps <= '0;
    end else case (state)
      S_IDLE: if (move_valid_in && move_ready_out) begin
        move  <= move_in;
        state <= S_CHECK;
      end
      S_CHECK: if (is_pass) begin
        result    <= RES_PASS;
        turn      <= ~turn;
        game_over <= game_over | pass_flag;
        pass_flag <= 1'b1;
        state     <= S_REPORT;
      end else if (!in_range || target != EMPTY) begin
        result <= RES_ILLEGAL;
        state  <= S_REPORT;
      end else begin
        pass_flag <= 1'b0;
        state     <= S_LAUNCH;
      end
      S_LAUNCH: state <= S_WAIT_UPD;
      S_WAIT_UPD: if (upd_ready_in) begin
        new_board <= upd_board_in;
        state     <= S_KO_CHECK;
      end
      S_KO_CHECK: begin
        result <= suicide ? RES_ILLEGAL : ko ? RES_KO : RES_OK;
        state  <= S_COMMIT;
      end
      S_COMMIT: begin
        if (result == RES_OK) begin
          board <= new_board;
          turn  <= ~turn;
          if (turn) white_caps <= caps_next;
          else black_caps <= caps_next;
        end
        state <= S_REPORT;
      end
      default: state <= S_IDLE;
    endcase

  assign move_ready_out = state == S_IDLE && !game_over;
  assign upd_start_out = state == S_LAUNCH;
  assign upd_board_out = board;
  assign upd_turn_out = turn;
  assign upd_move_out = move;
  assign board_out = board;
  assign turn_out = turn;
  assign result_valid_out = state == S_REPORT;
  assign result_code_out = result;
  assign black_caps_out = black_caps;
  assign white_caps_out = white_caps;
  assign game_over_out = game_over;
endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed tables and random play against a Go-rules reference model
module tb_move_controller;
  import go_pkg::*;

`ifdef KO_DETECT_EN
  localparam bit KO_ON = 1'b1;
`else
  localparam bit KO_ON = 1'b0;
`endif

  logic clk_in = 1'b0, rst_n_in = 1'b0, move_valid_in = 1'b0, upd_ready_in;
  logic [7:0] move_in = 8'h00;
  board_t upd_board_in, upd_board_out, board_out;
  logic move_ready_out, upd_start_out, upd_turn_out, turn_out, result_valid_out, game_over_out;
  logic [7:0] upd_move_out, black_caps_out, white_caps_out;
  logic [1:0] result_code_out;

  move_controller dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .move_valid_in(move_valid_in), .move_in(move_in),
    .move_ready_out(move_ready_out), .upd_start_out(upd_start_out), .upd_board_out(upd_board_out),
    .upd_turn_out(upd_turn_out), .upd_move_out(upd_move_out), .upd_board_in(upd_board_in),
    .upd_ready_in(upd_ready_in), .board_out(board_out), .turn_out(turn_out),
    .result_valid_out(result_valid_out), .result_code_out(result_code_out),
    .black_caps_out(black_caps_out), .white_caps_out(white_caps_out), .game_over_out(game_over_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int passed = 0, total = 0;
  logic [7:0] cur_mv = 8'h00;

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s move=%h got=%0h expected=%0h", name, cur_mv, act, exp);
  endtask

  // reference model: committed position, previous position, turn, captures, pass/game-over
  int mb[9][9], mprev[9][9], wg[9][9];
  int mturn, mpass, mgo;
  int mcap[2];
  int grp[$];

  function automatic logic [161:0] bits_of(input bit w);
    logic [161:0] b;
    b = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        b[(r*9+c)*2 +: 2] = 2'(w ? wg[r][c] : mb[r][c]);
    return b;
  endfunction

  task automatic group_at(input int r0, input int c0, output int libs);
    int seen[9][9];
    int q[$];
    int col, p, r, c, nr, nc;
    for (int r1 = 0; r1 < 9; r1++) for (int c1 = 0; c1 < 9; c1++) seen[r1][c1] = 0;
    col = wg[r0][c0];
    grp = {};
    libs = 0;
    q.push_back(r0*9+c0);
    seen[r0][c0] = 1;
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / 9;
      c = p % 9;
      grp.push_back(p);
      for (int d = 0; d < 4; d++) begin
        nr = r + (d == 0 ? -1 : d == 1 ? 1 : 0);
        nc = c + (d == 2 ? -1 : d == 3 ? 1 : 0);
        if (nr >= 0 && nr < 9 && nc >= 0 && nc < 9 && seen[nr][nc] == 0) begin
          if (wg[nr][nc] == 0) begin libs++; seen[nr][nc] = 1; end
          else if (wg[nr][nc] == col) begin seen[nr][nc] = 1; q.push_back(nr*9+nc); end
        end
      end
    end
  endtask

  // place a stone on wg, remove dead opponent groups, then a dead own group (suicide)
  task automatic place(input int r, input int c, input int col, output int caps);
    int libs, nr, nc;
    caps = 0;
    wg[r][c] = col;
    for (int d = 0; d < 4; d++) begin
      nr = r + (d == 0 ? -1 : d == 1 ? 1 : 0);
      nc = c + (d == 2 ? -1 : d == 3 ? 1 : 0);
      if (nr >= 0 && nr < 9 && nc >= 0 && nc < 9 && wg[nr][nc] == 3 - col) begin
        group_at(nr, nc, libs);
        if (libs == 0) foreach (grp[i]) begin wg[grp[i]/9][grp[i]%9] = 0; caps++; end
      end
    end
    group_at(r, c, libs);
    if (libs == 0) foreach (grp[i]) wg[grp[i]/9][grp[i]%9] = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) begin mb[r][c] = 0; mprev[r][c] = 0; end
    mturn = 0; mpass = 0; mgo = 0; mcap[0] = 0; mcap[1] = 0;
  endtask

  task automatic step_model(input logic [7:0] mv, output logic [1:0] code, output bit launch);
    int r, c, caps;
    bit same;
    launch = 1'b0;
    r = int'(mv[7:4]);
    c = int'(mv[3:0]);
    if (mv == 8'hFF) begin
      code = 2'b11; mturn = 1 - mturn;
      if (mpass != 0) mgo = 1;
      mpass = 1;
    end else if (r > 8 || c > 8) code = 2'b01;
    else if (mb[r][c] != 0) code = 2'b01;
    else begin
      launch = 1'b1; mpass = 0;
      wg = mb;
      place(r, c, mturn != 0 ? 2 : 1, caps);
      same = 1'b1;
      for (int r1 = 0; r1 < 9; r1++) for (int c1 = 0; c1 < 9; c1++) if (wg[r1][c1] != mprev[r1][c1]) same = 1'b0;
      if (wg[r][c] == 0) code = 2'b01;
      else if (KO_ON && same) code = 2'b10;
      else begin
        code = 2'b00;
        mprev = mb;
        mb = wg;
        mcap[mturn] = mcap[mturn] + caps > 255 ? 255 : mcap[mturn] + caps;
        mturn = 1 - mturn;
      end
    end
  endtask

  // behavioural update stage: plays the latched move with Go capture rules after a variable delay
  int n_start = 0, ue = 0, upd_delay = 1;
  bit mute = 1'b0, spur = 1'b0;
  initial begin
    logic [161:0] ub;
    logic [7:0] um;
    logic ut;
    int caps;
    upd_ready_in = 1'b0;
    upd_board_in = board_t'(162'd0);
    forever begin
      @(posedge clk_in); #1;
      if (upd_start_out) begin
        n_start++;
        ub = upd_board_out; um = upd_move_out; ut = upd_turn_out;
        if (!mute) begin
          for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) wg[r][c] = int'(ub[(r*9+c)*2 +: 2]);
          place(int'(um[7:4]), int'(um[3:0]), ut ? 2 : 1, caps);
          repeat (upd_delay) @(posedge clk_in);
          #1;
          chk("upd_board_stable", upd_board_out, ub);
          chk("upd_move_stable", upd_move_out, um);
          chk("upd_turn_stable", upd_turn_out, ut);
          upd_board_in = board_t'(bits_of(1'b1));
          upd_ready_in = 1'b1;
          ue = cyc;
          @(posedge clk_in); #1;
          upd_ready_in = 1'b0;
        end
      end else if (spur) begin
        upd_board_in = board_t'({162{1'b1}});
        upd_ready_in = 1'b1;
        @(posedge clk_in); #1;
        upd_ready_in = 1'b0;
        spur = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] mv, input bit launch, output logic [1:0] got);
    int t, s0, hs;
    cur_mv = mv;
    @(negedge clk_in);
    move_valid_in = 1'b1; move_in = mv; s0 = n_start;
    t = 0;
    while (!move_ready_out && t < 20) begin @(negedge clk_in); t++; end
    hs = cyc;
    @(posedge clk_in); #1;
    move_valid_in = 1'b0; move_in = 8'($urandom);
    t = 0;
    while (!result_valid_out && t < 60) begin @(posedge clk_in); #1; t++; end
    chk("result_timeout", t < 60, 1);
    got = result_code_out;
    chk("latency", cyc, launch ? ue + 3 : hs + 2);
    chk("launch_count", n_start - s0, launch);
    @(posedge clk_in); #1;
    chk("valid_one_cycle", result_valid_out, 0);
  endtask

  task automatic play(input logic [7:0] mv, output logic [1:0] got);
    logic [1:0] ec;
    bit la;
    step_model(mv, ec, la);
    send(mv, la, got);
    chk("code", got, ec);
    chk("board", board_out, bits_of(1'b0));
    chk("turn", turn_out, mturn);
    chk("black_caps", black_caps_out, mcap[0]);
    chk("white_caps", white_caps_out, mcap[1]);
    chk("game_over", game_over_out, mgo);
    chk("ready", move_ready_out, mgo == 0);
  endtask

  task automatic reset_checks();
    chk("rst_ready", move_ready_out, 1);
    chk("rst_start", upd_start_out, 0);
    chk("rst_board", board_out, 0);
    chk("rst_turn", turn_out, 0);
    chk("rst_valid", result_valid_out, 0);
    chk("rst_code", result_code_out, 0);
    chk("rst_caps", {black_caps_out, white_caps_out}, 0);
    chk("rst_game_over", game_over_out, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in); rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic play_list(input logic [7:0] mvs[$]);
    logic [1:0] got;
    foreach (mvs[i]) play(mvs[i], got);
  endtask

  typedef struct {
    logic [7:0] mv;
    logic [1:0] code;
    logic turn;
    logic go;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [1:0] got;
    logic [7:0] mv;
    int k, s, seen;
    tbl[0] = '{8'h44, 2'b00, 1'b1, 1'b0};
    tbl[1] = '{8'h44, 2'b01, 1'b1, 1'b0};
    tbl[2] = '{8'h49, 2'b01, 1'b1, 1'b0};
    tbl[3] = '{8'h94, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{8'h33, 2'b00, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 2'b11, 1'b1, 1'b0};
    tbl[6] = '{8'h55, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 2'b11, 1'b1, 1'b0};
    tbl[8] = '{8'hFF, 2'b11, 1'b0, 1'b1};
    model_reset();
    repeat (2) @(negedge clk_in);
    reset_checks();
    rst_n_in = 1'b1;

    for (int i = 0; i < 9; i++) begin
      play(tbl[i].mv, got);
      chk("tbl_code", got, tbl[i].code);
      chk("tbl_turn", turn_out, tbl[i].turn);
      chk("tbl_game_over", game_over_out, tbl[i].go);
      if (i == 0) chk("tbl_cell44", board_out[4][4], 2'b01);
    end

    seen = 0;
    @(negedge clk_in); move_valid_in = 1'b1; move_in = 8'h22;
    repeat (8) begin @(posedge clk_in); #1; if (result_valid_out || upd_start_out) seen++; end
    move_valid_in = 1'b0;
    chk("ignored_after_game_over", seen, 0);

    do_reset();
    spur = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    chk("spurious_ready_board", board_out, 0);
    chk("spurious_ready_idle", move_ready_out, 1);

    play_list('{8'h01, 8'h00, 8'h10});
    chk("capture_code", result_code_out, 2'b00);
    chk("capture_black_caps", black_caps_out, 1);
    chk("capture_corner_empty", board_out[0][0], 2'b00);

    do_reset();
    play_list('{8'h88, 8'h01, 8'h87, 8'h10, 8'h00});
    chk("suicide_code", result_code_out, 2'b01);
    chk("suicide_turn", turn_out, 0);
    chk("suicide_corner", board_out[0][0], 2'b00);

    do_reset();
    play_list('{8'h01, 8'h02, 8'h21, 8'h22, 8'h10, 8'h13, 8'h88, 8'h11, 8'h12});
    chk("ko_take_black_caps", black_caps_out, 1);
    play_list('{8'h11});
    chk("ko_code", result_code_out, KO_ON ? 2'b10 : 2'b00);
    chk("ko_white_caps", white_caps_out, KO_ON ? 0 : 1);

    do_reset();
    play_list('{8'h44});
    mute = 1'b1;
    s = n_start;
    cur_mv = 8'h55;
    @(negedge clk_in); move_valid_in = 1'b1; move_in = 8'h55;
    @(posedge clk_in); #1; move_valid_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2;
    chk("reached_wait", n_start - s, 1);
    rst_n_in = 1'b0;
    #1;
    reset_checks();
    @(negedge clk_in); rst_n_in = 1'b1; mute = 1'b0;
    model_reset();
    play_list('{8'h55});

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 99);
      upd_delay = $urandom_range(1, 4);
      if (k < 8) mv = 8'hFF;
      else if (k < 13) mv = {4'($urandom_range(0, 15)), 4'($urandom_range(9, 15))};
      else if (k < 60) mv = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      else mv = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
      play(mv, got);
      if (mgo != 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1);
  end
endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Game-sequencing stage that wraps the board-update stage on both sides.
- Accepts player moves over a valid/ready handshake and owns the authoritative board, turn and capture counts.
- Rejects occupied, out-of-range, suicide and (optionally) simple-ko moves.
- Launches the update stage, then commits or discards its result; the renderer and scoring logic consume its outputs.

Parameters:
- BOARD_N, 9, board dimension; rows/cols 0..BOARD_N-1.
- CAP_W, 8, width of each capture counter.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; one clock; asynchronous, active-low.
- move_valid_in  input  1  move request valid.
- move_in  input  8  [7:4] row, [3:0] col; 8'hFF = pass.
- move_ready_out  output  1  high only in IDLE and not game over.
- upd_start_out  output  1  one-cycle start pulse to the update stage.
- upd_board_out  output  2x9x9  committed board driven to the update stage.
- upd_turn_out  output  1  current turn (0 black, 1 white).
- upd_move_out  output  8  latched move.
- upd_board_in  input  2x9x9  updated board from the update stage.
- upd_ready_in  input  1  update-stage done pulse.
- board_out  output  2x9x9  committed board.
- turn_out  output  1  side to move.
- result_valid_out  output  1  one-cycle pulse per accepted handshake.
- result_code_out  output  2  00 ok, 01 illegal, 10 ko, 11 pass.
- black_caps_out, white_caps_out  output  CAP_W  stones captured by each side.
- game_over_out  output  1  sticky after two consecutive passes.

Behaviour:
- Cell encoding: 00 empty, 01 black, 10 white. The mover's stone is {turn,~turn}.
- Reset (async, rst_n_in low): board all empty; turn 0; caps 0; game_over 0; result_valid 0; result_code 00; upd_start 0; move_ready 1; state IDLE; pass_flag 0.
- IDLE:
  - Handshake completes when move_valid_in && move_ready_out. Latch move_in, go to CHECK.
  - Requests while ready is low are ignored; no queuing.
- CHECK (1 cycle):
  - Pass: result 11, toggle turn. If pass_flag is set, set game_over; otherwise set pass_flag. Go to REPORT.
  - Row or col > 8, or target cell non-empty: result 01, turn unchanged, go to REPORT.
  - Otherwise go to LAUNCH.
  - Any non-pass, legal-so-far move clears pass_flag.
- LAUNCH: pulse upd_start_out for 1 cycle, go to WAIT_UPD. upd_board_out, upd_turn_out and upd_move_out stay stable from LAUNCH until leaving WAIT_UPD.
- WAIT_UPD:
  - On upd_ready_in high, capture upd_board_in into new_board and go to KO_CHECK.
  - upd_ready_in seen in any other state is ignored.
- KO_CHECK (1 cycle):
  - If new_board[row][col] == empty, it is suicide: result 01, board discarded.
  - Else if the KO_DETECT_EN condition hits: result 10, board discarded.
  - Else result 00.
- COMMIT (1 cycle), result 00 only:
  - prev_board <= board; board <= new_board; turn toggles.
  - Mover's caps += (opponent stones before) − (opponent stones after), saturating at all-ones.
- REPORT: result_valid_out high for exactly 1 cycle, then go to IDLE.
- Latency: fixed 3 cycles from upd_ready_in sampled high to result_valid_out high. Rejected or pass moves: result_valid_out 2 cycles after the handshake.
- game_over: move_ready_out held low until reset.
- Reset mid-operation: aborts immediately with no partial commit. The update stage's active-high reset is tied to ~rst_n_in at top level.

Optional Feature:
- Macro KO_DETECT_EN.
- Defined:
  - Keep prev_board, the board before the opponent's last committed move.
  - A move whose new_board equals prev_board is rejected with code 10.
  - prev_board resets to empty.
- Undefined: no prev_board storage; code 10 is never produced; ko moves commit.

Decomposition:
- Package go_pkg:
  - cell_t enum (EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10).
  - board_t (cell_t [8:0][8:0]).
  - PASS_MOVE=8'hFF.
  - result_t enum (RES_OK, RES_ILLEGAL, RES_KO, RES_PASS).
  - State enum.
- Sub-module stone_counter: combinational count of one colour over a board_t, 7-bit output. Instantiated twice (board and new_board).

Test Plan:
1. After reset, black move 8'h44 with model updater → result 00, board[4][4]=01, turn_out=1, upd_start_out pulsed once.
2. Move to occupied 8'h44, or to 8'h49 (col 9) → result 01, no upd_start_out, board and turn unchanged.
3. White stone at 0,0, black at 0,1; black plays 8'h10 → white stone removed, black_caps_out=1, result 00.
4. Black plays into a fully surrounded empty corner (updater returns empty target) → result 01, board unchanged.
5. With KO_DETECT_EN defined, set up a ko; white recaptures immediately → result 10, caps unchanged. Without it → result 00.
6. 8'hFF twice → result 11 both times, game_over_out=1, move_ready_out=0. Drop rst_n_in mid-WAIT_UPD → all outputs at reset values immediately.
